// File: rtl/io_poll_master_pkg.sv
// Shared op encodings and default memory-mapped IO addresses for the polled-IO master.
package io_poll_master_pkg;

  typedef enum logic [1:0] {
    OP_RD_SW  = 2'd0,
    OP_WR_LED = 2'd1,
    OP_RD_POL = 2'd2,
    OP_WR_POL = 2'd3
  } op_e;

  localparam logic [7:0] IO_ADDR_LED         = 8'h00;
  localparam logic [7:0] IO_ADDR_SW          = 8'h04;
  localparam logic [7:0] IO_ADDR_POL_OUT_VLD = 8'h08;
  localparam logic [7:0] IO_ADDR_POL_OUT     = 8'h0C;
  localparam logic [7:0] IO_ADDR_POL_IN_VLD  = 8'h10;
  localparam logic [7:0] IO_ADDR_POL_IN      = 8'h14;

  function automatic logic op_is_write(input op_e op);
    return (op == OP_WR_LED) || (op == OP_WR_POL);
  endfunction

  function automatic logic op_is_polled(input op_e op);
    return (op == OP_RD_POL) || (op == OP_WR_POL);
  endfunction

endpackage

// File: rtl/io_poll_master.sv
// Command-driven master that runs the polled-IO handshakes (flag poll, gap, transfer)
// on the memory-mapped IO bus and returns one response per command.
module io_poll_master
  import io_poll_master_pkg::*;
#(
  parameter logic [7:0] ADDR_LED         = IO_ADDR_LED,
  parameter logic [7:0] ADDR_SW          = IO_ADDR_SW,
  parameter logic [7:0] ADDR_POL_OUT_VLD = IO_ADDR_POL_OUT_VLD,
  parameter logic [7:0] ADDR_POL_OUT     = IO_ADDR_POL_OUT,
  parameter logic [7:0] ADDR_POL_IN_VLD  = IO_ADDR_POL_IN_VLD,
  parameter logic [7:0] ADDR_POL_IN      = IO_ADDR_POL_IN,
  parameter int         POLL_GAP         = 2,
  parameter int         TIMEOUT          = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  io_addr,
  output logic [31:0] io_dout,
  output logic        io_we,
  output logic        io_rd,
  input  logic [31:0] io_din
);

  typedef enum logic [2:0] {S_IDLE, S_POLL, S_GAP, S_XFER, S_RESP} state_e;

  // GAP_LAST is never reached when POLL_GAP is 0, since GAP is then skipped.
  localparam logic [15:0] GAP_LAST    = 16'(POLL_GAP - 1);
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_e      state, state_nxt;
  op_e         op_q;
  logic [31:0] wdata_q;
  logic [15:0] poll_cnt, poll_cnt_nxt, poll_inc;
  logic [15:0] gap_cnt, gap_cnt_nxt;
  logic [31:0] rdata_nxt;
  logic        err_nxt;
  logic        poll_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_RD_SW;
      wdata_q  <= '0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      poll_cnt <= poll_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      rsp_data <= rdata_nxt;
      rsp_err  <= err_nxt;
      if (state == S_IDLE && cmd_valid) begin
        op_q    <= op_e'(cmd_op);
        wdata_q <= cmd_wdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    poll_cnt_nxt = poll_cnt;
    gap_cnt_nxt  = gap_cnt;
    rdata_nxt    = rsp_data;
    err_nxt      = rsp_err;
    // Input flag must be set to read; output flag must be clear to write.
    poll_ok      = (op_q == OP_RD_POL) ? io_din[0] : ~io_din[0];
    poll_inc     = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          poll_cnt_nxt = '0;
          rdata_nxt    = '0;
          err_nxt      = 1'b0;
          state_nxt    = op_is_polled(op_e'(cmd_op)) ? S_POLL : S_XFER;
        end
      end
      S_POLL: begin
        if (poll_ok) begin
          state_nxt = S_XFER;
        end else begin
          poll_cnt_nxt = poll_inc;
          if (TIMEOUT != 0 && poll_inc == TIMEOUT_CNT) begin
            state_nxt = S_RESP;
            err_nxt   = 1'b1;
            rdata_nxt = '0;
          end else if (POLL_GAP == 0) begin
            state_nxt = S_POLL;
          end else begin
            state_nxt   = S_GAP;
            gap_cnt_nxt = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_POLL;
        else gap_cnt_nxt = gap_cnt + 16'd1;
      end
      S_XFER: begin
        rdata_nxt = op_is_write(op_q) ? '0 : io_din;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus and handshake outputs decode only registered state and latched command.
  always_comb begin
    cmd_ready = (state == S_IDLE) && !rst;
    rsp_valid = (state == S_RESP);
    io_rd     = 1'b0;
    io_we     = 1'b0;
    io_addr   = '0;
    io_dout   = '0;
    unique case (state)
      S_POLL: begin
        io_rd   = 1'b1;
        io_addr = (op_q == OP_RD_POL) ? ADDR_POL_IN_VLD : ADDR_POL_OUT_VLD;
      end
      S_XFER: begin
        unique case (op_q)
          OP_RD_SW:  begin io_rd = 1'b1; io_addr = ADDR_SW; end
          OP_RD_POL: begin io_rd = 1'b1; io_addr = ADDR_POL_IN; end
          OP_WR_LED: begin io_we = 1'b1; io_addr = ADDR_LED;     io_dout = wdata_q; end
          OP_WR_POL: begin io_we = 1'b1; io_addr = ADDR_POL_OUT; io_dout = wdata_q; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_poll_master.sv
// Randomized bench for io_poll_master: per-cycle expected bus/handshake trace built
// from the command rules, checked by one compare process, plus directed literal checks.
module tb_io_poll_master;
  import io_poll_master_pkg::*;

  localparam int GAP = 2;
  localparam int TMO = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_data;
  logic [7:0]  io_addr;
  logic [31:0] io_dout, io_din;
  logic        io_we, io_rd;

  always #5 clk = ~clk;

  io_poll_master #(.POLL_GAP(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd), .io_din(io_din)
  );

  // Peripheral model: read data depends only on the current address/strobe.
  logic [31:0] sw_val = '0, in_data = '0, junk = '0;
  logic        in_vld = 1'b0, out_vld = 1'b0;
  always_comb begin
    io_din = junk;
    if (io_rd) begin
      case (io_addr)
        8'h04:   io_din = sw_val;
        8'h08:   io_din = {junk[31:1], out_vld};
        8'h10:   io_din = {junk[31:1], in_vld};
        8'h14:   io_din = in_data;
        default: io_din = junk;
      endcase
    end
  end

  typedef struct {
    logic        rd, we;
    logic [7:0]  addr;
    logic [31:0] dout;
    logic        crdy, rvld;
    logic [31:0] rdata;
    logic        rerr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  bit   chk_en = 1'b0;
  int   rd_cnt[256];
  int   we_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_rerr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL trace_underflow: no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("io_rd",     32'(io_rd),     32'(e.rd));
        check("io_we",     32'(io_we),     32'(e.we));
        check("io_addr",   32'(io_addr),   32'(e.addr));
        check("io_dout",   io_dout,        e.dout);
        check("cmd_ready", 32'(cmd_ready), 32'(e.crdy));
        check("rsp_valid", 32'(rsp_valid), 32'(e.rvld));
        if (e.rvld) begin
          check("rsp_data", rsp_data,     e.rdata);
          check("rsp_err",  32'(rsp_err), 32'(e.rerr));
        end
        if (io_rd) rd_cnt[io_addr]++;
        if (io_we) we_cnt++;
        if (rsp_valid && rsp_ready) begin
          last_rdata = rsp_data;
          last_rerr  = rsp_err;
        end
      end
    end
  end

  function automatic exp_t idle(input logic crdy);
    exp_t e;
    e.rd = 1'b0; e.we = 1'b0; e.addr = '0; e.dout = '0;
    e.crdy = crdy; e.rvld = 1'b0; e.rdata = '0; e.rerr = 1'b0;
    return e;
  endfunction

  // Inputs for the current cycle are already driven; queue its expectation and advance.
  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    junk = $urandom;
  endtask

  // While busy the source keeps offering junk commands; none may be taken.
  task automatic busy_inputs();
    cmd_valid = 1'($urandom);
    cmd_op    = 2'($urandom);
    cmd_wdata = $urandom;
    in_vld    = 1'($urandom);
    out_vld   = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      rsp_ready = 1'($urandom);
      cyc(idle(1'b1));
    end
  endtask

  // k = number of failed polls before the flag is good; d = cycles rsp_ready is held low.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] wd, input logic [31:0] sw,
                         input logic [31:0] ind, input int k, input int d);
    exp_t        e;
    bit          polled, tmo;
    int          polls;
    logic [31:0] rd_exp;
    polled  = op[1];
    tmo     = polled && (k >= TMO);
    polls   = !polled ? 0 : (tmo ? TMO : k + 1);
    rd_exp  = tmo ? 32'd0 : (op == 2'd0 ? sw : (op == 2'd2 ? ind : 32'd0));
    sw_val  = sw;
    in_data = ind;
    cmd_valid = 1'b1; cmd_op = op; cmd_wdata = wd; rsp_ready = 1'($urandom);
    cyc(idle(1'b1));
    for (int p = 0; p < polls; p++) begin
      busy_inputs();
      in_vld  = (p >= k);
      out_vld = !(p >= k);
      e = idle(1'b0);
      e.rd = 1'b1;
      e.addr = (op == 2'd2) ? 8'h10 : 8'h08;
      cyc(e);
      if (p < k && !(tmo && p == polls - 1))
        for (int g = 0; g < GAP; g++) begin busy_inputs(); cyc(idle(1'b0)); end
    end
    if (!tmo) begin
      busy_inputs();
      e = idle(1'b0);
      case (op)
        2'd0: begin e.rd = 1'b1; e.addr = 8'h04; end
        2'd1: begin e.we = 1'b1; e.addr = 8'h00; e.dout = wd; end
        2'd2: begin e.rd = 1'b1; e.addr = 8'h14; end
        default: begin e.we = 1'b1; e.addr = 8'h0C; e.dout = wd; end
      endcase
      cyc(e);
    end
    for (int r = 0; r <= d; r++) begin
      busy_inputs();
      rsp_ready = (r == d);
      e = idle(1'b0);
      e.rvld = 1'b1; e.rdata = rd_exp; e.rerr = tmo;
      cyc(e);
    end
  endtask

  initial begin
    int rd_all0, we0, r10, r14, r08;
    foreach (rd_cnt[i]) rd_cnt[i] = 0;

    // Reset values while rst is held.
    repeat (2) @(posedge clk);
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  rsp_data,       32'd0);
    check("rst_io_bus",    {io_addr, 22'd0, io_we, io_rd}, 32'd0);
    check("rst_io_dout",   io_dout,        32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    run_cmd(2'd0, 32'd0, 32'h0000_A5A5, 32'd0, 0, 0);
    check("rd_sw_data", last_rdata, 32'h0000_A5A5);

    rd_all0 = 0; foreach (rd_cnt[i]) rd_all0 += rd_cnt[i];
    we0 = we_cnt;
    run_cmd(2'd1, 32'h0000_1234, 32'd0, 32'd0, 0, 1);
    begin
      int rd_all1 = 0;
      foreach (rd_cnt[i]) rd_all1 += rd_cnt[i];
      check("wr_led_rd_count", 32'(rd_all1 - rd_all0), 32'd0);
    end
    check("wr_led_we_count", 32'(we_cnt - we0), 32'd1);
    check("wr_led_data", last_rdata, 32'd0);

    r10 = rd_cnt[8'h10]; r14 = rd_cnt[8'h14];
    run_cmd(2'd2, 32'd0, 32'd0, 32'hDEAD_BEEF, 3, 0);
    check("rd_pol_flag_polls", 32'(rd_cnt[8'h10] - r10), 32'd4);
    check("rd_pol_data_reads", 32'(rd_cnt[8'h14] - r14), 32'd1);
    check("rd_pol_data", last_rdata, 32'hDEAD_BEEF);

    r08 = rd_cnt[8'h08]; we0 = we_cnt;
    run_cmd(2'd3, 32'h5555_AAAA, 32'd0, 32'd0, 100, 0);
    check("wr_pol_tmo_polls", 32'(rd_cnt[8'h08] - r08), 32'd5);
    check("wr_pol_tmo_we",    32'(we_cnt - we0), 32'd0);
    check("wr_pol_tmo_err",   32'(last_rerr), 32'd1);
    check("wr_pol_tmo_data",  last_rdata, 32'd0);

    // Held response, then back-to-back command the cycle after the handshake.
    run_cmd(2'd0, 32'd0, 32'h1357_9BDF, 32'd0, 0, 10);
    run_cmd(2'd3, 32'hC0DE_0001, 32'd0, 32'd0, 1, 2);

    for (int n = 0; n < 40; n++) begin
      idle_cycles($urandom_range(0, 2));
      run_cmd(2'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, 6), $urandom_range(0, 3));
    end
    chk_en = 1'b0;

    // Reset during the gap of a stuck WR_POL.
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_wdata = 32'hCAFE_F00D;
    out_vld = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("mid_rst_poll_rd", 32'(io_rd), 32'd1);
    @(posedge clk); #3;
    check("mid_rst_gap_rd", 32'(io_rd), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_bus",       {io_addr, 22'd0, io_we, io_rd}, 32'd0);
    check("mid_rst_dout",      io_dout, 32'd0);
    check("mid_rst_rsp",       {rsp_err, 30'd0, rsp_valid}, 32'd0);
    check("mid_rst_rsp_data",  rsp_data, 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("in_rst_we",    32'(io_we), 32'd0);
      check("in_rst_ready", 32'(cmd_ready), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_bus", {io_addr, 22'd0, io_we, io_rd}, 32'd0);
      check("post_rst_idle_ready", 32'(cmd_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
